// File: rtl/nios_debug_cmd_bridge.sv
// System-clock receiver for virtual-JTAG debug commands: synchronises update-IR/DR
// events, queues {IR, data} pairs and hands them out with per-IR action strobes.
module nios_debug_cmd_bridge #(
   parameter int unsigned DATA_W      = 38,
   parameter int unsigned IR_W        = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ACT_BIT     = 35
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          vs_udr,
   input  logic                          vs_uir,
   input  logic [IR_W-1:0]               ir_in,
   input  logic [DATA_W-1:0]             sr,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [IR_W-1:0]               cmd_ir,
   output logic [DATA_W-1:0]             jdo,
   output logic [(1<<IR_W)-1:0]          take_action,
   output logic [(1<<IR_W)-1:0]          take_no_action,
   output logic                          ir_update,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          clr_overflow
);

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned ENT_W = IR_W + DATA_W;
   localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);

   logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
   logic                   udr_edge_q, uir_edge_q;
   logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
   logic                   armed;
   logic                   udr_pulse, uir_pulse;

   logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
   logic [AW:0]            wr_ptr_q, wr_ptr_d;
   logic [AW:0]            rd_ptr_q, rd_ptr_d;
   logic                   overflow_q, overflow_d;
   logic                   full, empty, pop, push_acc, drop;
   logic [ENT_W-1:0]       head;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         udr_sync_q <= '0;
         uir_sync_q <= '0;
         udr_edge_q <= 1'b0;
         uir_edge_q <= 1'b0;
         arm_cnt_q  <= ARM_W'(SYNC_STAGES + 1);
      end else begin
         udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
         uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
         udr_edge_q <= udr_sync_q[SYNC_STAGES-1];
         uir_edge_q <= uir_sync_q[SYNC_STAGES-1];
         arm_cnt_q  <= arm_cnt_d;
      end
   end

   // Edge flops keep tracking while disarmed, so a level already high at
   // reset release is absorbed and never seen as a rising edge.
   always_comb begin
      arm_cnt_d = arm_cnt_q;
      if (arm_cnt_q != '0) arm_cnt_d = arm_cnt_q - 1'b1;
   end

   assign armed     = (arm_cnt_q == '0);
   assign udr_pulse = armed & udr_sync_q[SYNC_STAGES-1] & ~udr_edge_q;
   assign uir_pulse = armed & uir_sync_q[SYNC_STAGES-1] & ~uir_edge_q;
   assign ir_update = uir_pulse;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) & (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign cmd_valid = ~empty;
   assign pop      = cmd_valid & cmd_ready;
   assign push_acc = udr_pulse & (~full | pop);
   assign drop     = udr_pulse & full & ~pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_acc};
      rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
      overflow_d = overflow_q;
      if (clr_overflow) overflow_d = 1'b0;
      if (drop)         overflow_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         if (push_acc) mem_q[wr_ptr_q[AW-1:0]] <= {ir_in, sr};
      end
   end

   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign cmd_ir     = head[ENT_W-1 -: IR_W];
   assign jdo        = head[DATA_W-1:0];
   assign fifo_level = wr_ptr_q - rd_ptr_q;
   assign overflow   = overflow_q;

   always_comb begin
      take_action    = '0;
      take_no_action = '0;
      if (pop) begin
         if (jdo[ACT_BIT]) take_action[cmd_ir]    = 1'b1;
         else              take_no_action[cmd_ir] = 1'b1;
      end
   end

endmodule

// File: tb/tb_nios_debug_cmd_bridge.sv
// Scoreboard bench for nios_debug_cmd_bridge: stimulus queues expected commands,
// a negedge monitor checks every pop and idle strobes.
module tb_nios_debug_cmd_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        vs_udr, vs_uir;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_ir;
   logic [37:0] jdo;
   logic [3:0]  take_action, take_no_action;
   logic        ir_update;
   logic [2:0]  fifo_level;
   logic        overflow, clr_overflow;

   int checks = 0;
   int errors = 0;
   logic [39:0] exp_q [$];

   nios_debug_cmd_bridge #(
      .DATA_W(38), .IR_W(2), .SYNC_STAGES(2), .FIFO_DEPTH(4), .ACT_BIT(35)
   ) dut (
      .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
      .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .jdo(jdo), .take_action(take_action),
      .take_no_action(take_no_action), .ir_update(ir_update),
      .fifo_level(fifo_level), .overflow(overflow), .clr_overflow(clr_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [1:0] ir, input logic [37:0] d, input bit keep);
      ir_in  = ir;
      sr     = d;
      vs_udr = 1'b1;
      if (keep) exp_q.push_back({ir, d});
      repeat (4) tick();
      vs_udr = 1'b0;
      repeat (4) tick();
   endtask

   // Monitor: every pop must match the scoreboard head, otherwise strobes stay quiet
   always @(negedge clk) begin
      logic [39:0] e;
      logic [3:0]  ea, en;
      if (cmd_valid && cmd_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop", 64'(cmd_valid), 64'd0);
         end else begin
            e  = exp_q.pop_front();
            ea = '0;
            en = '0;
            if (e[35]) ea[e[39:38]] = 1'b1;
            else       en[e[39:38]] = 1'b1;
            check("pop_cmd_ir", 64'(cmd_ir), 64'(e[39:38]));
            check("pop_jdo", 64'(jdo), 64'(e[37:0]));
            check("pop_take_action", 64'(take_action), 64'(ea));
            check("pop_take_no_action", 64'(take_no_action), 64'(en));
         end
      end else begin
         check("idle_strobes", 64'({take_action, take_no_action}), 64'd0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; vs_udr = 1'b1; vs_uir = 1'b0; ir_in = '0; sr = '0;
      cmd_ready = 1'b0; clr_overflow = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_fifo_level", 64'(fifo_level), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_jdo", 64'(jdo), 64'd0);
      check("rst_cmd_ir", 64'(cmd_ir), 64'd0);
      check("rst_ir_update", 64'(ir_update), 64'd0);

      // udr held high through reset release must not create an entry
      repeat (8) tick();
      check("arm_mask_level", 64'(fifo_level), 64'd0);
      vs_udr = 1'b0;
      repeat (4) tick();
      send(2'd3, 38'h12_3456_789A, 1'b1);
      @(negedge clk);
      check("rearm_level", 64'(fifo_level), 64'd1);
      tick();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      @(negedge clk);
      check("rearm_drained", 64'(fifo_level), 64'd0);

      // Latency: valid appears 3 edges after the udr rise
      tick();
      ir_in = 2'd2; sr = 38'h08_0000_0001; vs_udr = 1'b1;
      exp_q.push_back({2'd2, 38'h08_0000_0001});
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("lat_valid_early", 64'(cmd_valid), 64'd0);
      @(negedge clk);
      check("lat_valid", 64'(cmd_valid), 64'd1);
      check("lat_jdo", 64'(jdo), 64'h08_0000_0001);
      check("lat_cmd_ir", 64'(cmd_ir), 64'd2);
      tick();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      @(negedge clk);
      check("pop_valid_drop", 64'(cmd_valid), 64'd0);
      tick();
      vs_udr = 1'b0;
      repeat (4) tick();

      // No-action command popped as soon as it lands
      cmd_ready = 1'b1;
      send(2'd1, 38'h37_0000_0055, 1'b1);
      cmd_ready = 1'b0;

      // ir_update pulse, FIFO untouched
      vs_uir = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("uir_early", 64'(ir_update), 64'd0);
      @(negedge clk);
      check("uir_pulse", 64'(ir_update), 64'd1);
      @(negedge clk);
      check("uir_single", 64'(ir_update), 64'd0);
      check("uir_level", 64'(fifo_level), 64'd0);
      tick();
      vs_uir = 1'b0;
      repeat (4) tick();

      // Overflow: five pushes into a four-deep FIFO
      send(2'd0, 38'h20_0000_0011, 1'b1);
      send(2'd1, 38'h00_0000_0022, 1'b1);
      send(2'd2, 38'h08_0000_0033, 1'b1);
      send(2'd3, 38'h00_0000_0044, 1'b1);
      send(2'd0, 38'h3F_FFFF_FFFF, 1'b0);
      @(negedge clk);
      check("ovf_level", 64'(fifo_level), 64'd4);
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_head_jdo", 64'(jdo), 64'h20_0000_0011);
      check("ovf_head_ir", 64'(cmd_ir), 64'd0);
      tick();
      cmd_ready = 1'b1;
      repeat (4) tick();
      cmd_ready = 1'b0;
      @(negedge clk);
      check("ovf_drained", 64'(fifo_level), 64'd0);
      check("ovf_sticky", 64'(overflow), 64'd1);
      tick();
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      @(negedge clk);
      check("ovf_cleared", 64'(overflow), 64'd0);
      tick();

      // Full FIFO with a pop coinciding with the push pulse
      send(2'd1, 38'h08_0000_0101, 1'b1);
      send(2'd2, 38'h00_0000_0202, 1'b1);
      send(2'd3, 38'h08_0000_0303, 1'b1);
      send(2'd0, 38'h00_0000_0404, 1'b1);
      ir_in = 2'd2; sr = 38'h08_0000_0505; vs_udr = 1'b1;
      exp_q.push_back({2'd2, 38'h08_0000_0505});
      @(posedge clk);
      @(posedge clk);
      #2 cmd_ready = 1'b1;
      @(posedge clk);
      #2 cmd_ready = 1'b0;
      @(negedge clk);
      check("fullpop_level", 64'(fifo_level), 64'd4);
      check("fullpop_overflow", 64'(overflow), 64'd0);
      tick();
      vs_udr = 1'b0;
      repeat (4) tick();
      cmd_ready = 1'b1;
      repeat (4) tick();
      cmd_ready = 1'b0;
      @(negedge clk);
      check("fullpop_drained", 64'(fifo_level), 64'd0);
      tick();

      // Asynchronous reset discards queued entries
      send(2'd1, 38'h00_0000_0A0A, 1'b0);
      send(2'd2, 38'h00_0000_0B0B, 1'b0);
      send(2'd3, 38'h00_0000_0C0C, 1'b0);
      @(negedge clk);
      check("pre_rst_level", 64'(fifo_level), 64'd3);
      tick();
      reset = 1'b1;
      #1;
      check("midrst_valid", 64'(cmd_valid), 64'd0);
      check("midrst_level", 64'(fifo_level), 64'd0);
      repeat (2) tick();
      reset = 1'b0;
      repeat (6) tick();
      check("post_rst_level", 64'(fifo_level), 64'd0);
      cmd_ready = 1'b1;
      send(2'd0, 38'h08_DEAD_BEEF, 1'b1);
      cmd_ready = 1'b0;
      repeat (2) tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
